native_to_axis_fifo: RTL
========================

# native_to_axis_fifo

Converts native video timing (vsync/hsync/de + pixel) into an AXI4-Stream video interface (tuser = start of frame, tlast = end of line) and adds real `axi_tready` backpressure through an internal first-word-fall-through FIFO. Frames are forwarded whole. After an overflow, the rest of the frame is discarded, so downstream never starts mid-frame. Line length is checked against a programmed value. The block sits between the video timing/capture front end and the AXI VDMA write channel.

## Interface
- `DSIZE`, 24, pixel width in bits.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, at least 4.
- `LINE_PIXELS`, 1920, expected active pixels per line.
- `VS_POL`, "HIGH", vsync active level ("HIGH"/"LOW"); frame start = vsync deassertion edge.
- `clock`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  capture enable; effective de = `de & enable`.
- `vsync`, `hsync`, `de`  in  1 each  native timing; `hsync` is not used for framing.
- `idata`  in  DSIZE  pixel data, valid when effective de is high.
- `clear_err`  in  1  single-cycle clear of the sticky flags.
- `aclk`, `aclken`, `aresetn`  out  1 each  equal to `clock`, `enable`, `~rst`.
- `axi_tdata`  out  DSIZE; `axi_tvalid` out 1; `axi_tready` in 1; `axi_tuser` out 1; `axi_tlast` out 1.
- `overflow`  out  1  sticky: a pixel was dropped because the FIFO was full.
- `line_err`  out  1  sticky: a completed line length was not equal to LINE_PIXELS.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Inputs are registered once. Vsync deassertion is detected against its previous value and gives `sof_evt`. Effective de is compared with its previous value to find line ends.
- Staging register, one pixel deep:
  - A sampled pixel is held in the staging register.
  - On the next cycle it is pushed with last=0 if effective de is still high, or with last=1 if effective de has fallen.
  - FIFO entry = {user, last, data}.
- `sof_evt` sets `sof_pend`. The next sampled pixel takes user=1 and clears `sof_pend`. If `sof_evt` and de arrive in the same cycle, that pixel takes user=1.
- State machine:
  - IDLE (after reset): discard all pixels. Go to PASS on `sof_evt`.
  - PASS: push entries as described above. If a push meets a full FIFO, drop that entry, set `overflow`, clear the staging register, and go to DROP.
  - DROP: discard all pixels. Go to PASS on the next `sof_evt`; the first pixel after it carries user=1.
  - Entries already in the FIFO when DROP is entered still drain. The truncated line carries no tlast.
- Line counter:
  - Counts pixels per line, saturating at LINE_PIXELS+1.
  - On each push with last=1 in PASS, a count not equal to LINE_PIXELS sets `line_err`.
  - The counter clears at line end and on `sof_evt`. Lines are still forwarded unchanged.
- Sticky flags clear on `rst` or `clear_err`. If a set event and `clear_err` occur in the same cycle, set wins.
- FIFO behaviour:
  - FWFT; `axi_tvalid` = !empty; a pop happens when `axi_tvalid & axi_tready`.
  - Push and pop in the same cycle are allowed when full; occupancy is unchanged and the push is accepted.
  - `axi_tdata`, `axi_tuser` and `axi_tlast` hold stable while `axi_tvalid & !axi_tready`.

## Timing
- Reset values:
  - `axi_tvalid`, `axi_tuser`, `axi_tlast`, `overflow`, `line_err` = 0; `axi_tdata` = 0; `fifo_level` = 0.
  - State = IDLE; `sof_pend` = 0; staging register empty.
- Reset applied mid-frame flushes the FIFO within the same edge. The block then waits in IDLE for a new frame start.
- Latency, empty FIFO, `axi_tready`=1: the pixel sampled at edge N appears on `axi_tvalid` after edge N+2 (input register, then staging register, then push). The last pixel of a line appears one cycle later than that, since it waits for the de fall.
- Sustained throughput is one pixel per clock while `axi_tready`=1.
- `overflow` asserts on the edge of the dropped push.

## Structure
- Package `native_axis_pkg` holds:
  - state enum {IDLE, PASS, DROP};
  - entry field offsets (USER_BIT, LAST_BIT);
  - a function for the entry width, DSIZE+2.
- Sub-module `sync_fifo_fwft` is parametrised by width and depth. It provides full, empty and level outputs, and pointers that are one bit wider than the address for wrap detection.

## Test plan
- Reset then pixels before any vsync edge, tready=1 -> no `axi_tvalid`; state remains IDLE.
- 3 lines of 4 pixels with data 1..12, LINE_PIXELS=4, tready=1 -> 12 beats in order:
  - tuser on beat 1 only; tlast on beats 4, 8, 12;
  - first tvalid 2 cycles after the first de sample;
  - `line_err`=0.
- FIFO_DEPTH=16, 8-pixel line, tready held low for 10 cycles then high -> all 8 beats delivered in order, no `overflow`, `fifo_level` peaks at 8.
- FIFO_DEPTH=4, tready=0, 8-pixel line -> `overflow`=1 at the 5th push:
  - FIFO holds beats 1..4;
  - remaining frame discarded;
  - after the next vsync, the frame is delivered intact with tuser on its first beat.
- Line of 3 pixels with LINE_PIXELS=4 -> `line_err`=1, 3 beats with tlast on beat 3. Then a `clear_err` pulse -> `line_err`=0.
- `sof_evt` in the same cycle as the first de -> that pixel carries tuser=1. `clear_err` in the same cycle as a new overflow -> `overflow` stays 1.

Source files
------------

// File: rtl/native_to_axis_fifo_pkg.sv
// Shared types and entry layout for the native-video to AXI4-Stream bridge.
package native_axis_pkg;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  // Sideband bit positions above the pixel field of a FIFO entry.
  localparam int LAST_BIT = 0;
  localparam int USER_BIT = 1;

  function automatic int entry_width(input int dsize);
    return dsize + 2;
  endfunction

endpackage

// File: rtl/native_to_axis_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible while not empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit separates full from empty when the addresses match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/native_to_axis_fifo.sv
// Native vsync/de video to AXI4-Stream video with FIFO backpressure,
// whole-frame forwarding and line-length checking.
module native_to_axis_fifo
  import native_axis_pkg::*;
#(
  parameter int    DSIZE       = 24,
  parameter int    FIFO_DEPTH  = 16,
  parameter int    LINE_PIXELS = 1920,
  parameter string VS_POL      = "HIGH"
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          vsync,
  input  logic                          hsync,
  input  logic                          de,
  input  logic [DSIZE-1:0]              idata,
  input  logic                          clear_err,
  output logic                          aclk,
  output logic                          aclken,
  output logic                          aresetn,
  output logic [DSIZE-1:0]              axi_tdata,
  output logic                          axi_tvalid,
  input  logic                          axi_tready,
  output logic                          axi_tuser,
  output logic                          axi_tlast,
  output logic                          overflow,
  output logic                          line_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int           EW       = entry_width(DSIZE);
  localparam int           CW       = $clog2(LINE_PIXELS + 2);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LINE_PIXELS + 1);
  localparam logic [CW-1:0] LINE_CNT = CW'(LINE_PIXELS);
  localparam logic         VS_ACT   = (VS_POL == "LOW") ? 1'b0 : 1'b1;

  logic             vs_q, vs_prev_q, de_q, de_prev_q, line_end_q;
  logic [DSIZE-1:0] data_q;
  state_e           state_q, state_d;
  logic             stg_valid_q, stg_valid_d;
  logic             stg_user_q, stg_user_d;
  logic [DSIZE-1:0] stg_data_q, stg_data_d;
  logic             sof_pend_q, sof_pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             line_err_q, line_err_d;

  logic             sof_evt, accept, push_req, push_ok, drop, load, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [EW-1:0]    fifo_wdata, fifo_rdata;
  logic             unused_hsync;

  assign unused_hsync = hsync;

  assign aclk    = clock;
  assign aclken  = enable;
  assign aresetn = ~rst;

  assign sof_evt  = vs_prev_q & ~vs_q;
  assign accept   = (state_q == PASS) | sof_evt;
  // A staged pixel leaves when the next pixel arrives or once the line end is known.
  assign push_req = stg_valid_q & (line_end_q | de_q);
  assign fifo_pop = axi_tvalid & axi_tready;
  assign push_ok  = push_req & (~fifo_full | fifo_pop);
  assign drop     = push_req & ~push_ok;
  assign load     = accept & de_q & ~drop;

  always_comb begin
    fifo_wdata                  = '0;
    fifo_wdata[DSIZE-1:0]       = stg_data_q;
    fifo_wdata[DSIZE+LAST_BIT]  = line_end_q;
    fifo_wdata[DSIZE+USER_BIT]  = stg_user_q;
  end

  always_comb begin
    state_d     = state_q;
    stg_valid_d = stg_valid_q;
    stg_user_d  = stg_user_q;
    stg_data_d  = stg_data_q;
    sof_pend_d  = sof_pend_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    line_err_d  = line_err_q;

    if (clear_err) begin
      overflow_d = 1'b0;
      line_err_d = 1'b0;
    end

    if (sof_evt) begin
      sof_pend_d = 1'b1;
      cnt_d      = '0;
    end
    if (line_end_q) cnt_d = '0;

    if (push_ok) stg_valid_d = 1'b0;

    if (load) begin
      stg_valid_d = 1'b1;
      stg_data_d  = data_q;
      stg_user_d  = sof_pend_q | sof_evt;
      sof_pend_d  = 1'b0;
      if (sof_evt | line_end_q) cnt_d = CW'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end

    if (push_ok && line_end_q && state_q == PASS && cnt_q != LINE_CNT) line_err_d = 1'b1;

    case (state_q)
      IDLE:    if (sof_evt) state_d = PASS;
      DROP:    if (sof_evt) state_d = PASS;
      default: state_d = state_q;
    endcase

    // Overflow abandons the rest of the frame; the next frame start resumes forwarding.
    if (drop) begin
      stg_valid_d = 1'b0;
      overflow_d  = 1'b1;
      state_d     = DROP;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      de_q        <= 1'b0;
      de_prev_q   <= 1'b0;
      line_end_q  <= 1'b0;
      data_q      <= '0;
      state_q     <= IDLE;
      stg_valid_q <= 1'b0;
      stg_user_q  <= 1'b0;
      stg_data_q  <= '0;
      sof_pend_q  <= 1'b0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      vs_q        <= (vsync == VS_ACT);
      vs_prev_q   <= vs_q;
      de_q        <= de & enable;
      de_prev_q   <= de_q;
      line_end_q  <= de_prev_q & ~de_q;
      data_q      <= idata;
      state_q     <= state_d;
      stg_valid_q <= stg_valid_d;
      stg_user_q  <= stg_user_d;
      stg_data_q  <= stg_data_d;
      sof_pend_q  <= sof_pend_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      line_err_q  <= line_err_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .push_i  (push_ok),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign axi_tvalid = ~fifo_empty;
  assign axi_tdata  = fifo_rdata[DSIZE-1:0];
  assign axi_tuser  = fifo_rdata[DSIZE+USER_BIT];
  assign axi_tlast  = fifo_rdata[DSIZE+LAST_BIT];
  assign overflow   = overflow_q;
  assign line_err   = line_err_q;

endmodule
